// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment display path.
// Segment vectors are active-low, bit [0]=a ... bit [6]=g.
package seg7_pkg;

    localparam int NUM_DIGITS = 3;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // Digit glyphs 0-9
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    // Digit slot index; only 0..IDX_LAST are ever used
    typedef logic [1:0] idx_t;

    localparam idx_t IDX_FIRST = 2'd0;
    localparam idx_t IDX_LAST  = 2'd2;

    // Next slot in the 0 -> 1 -> 2 -> 0 scan order
    function automatic idx_t idx_next(input idx_t i);
        return (i >= IDX_LAST) ? IDX_FIRST : idx_t'(i + 2'd1);
    endfunction

    // Active-low one-cold anode vector for a slot; out-of-range slot is all off
    function automatic logic [NUM_DIGITS-1:0] anode_sel(input idx_t i);
        logic [NUM_DIGITS-1:0] an;
        an = '1;
        case (i)
            2'd0:    an[0] = 1'b0;
            2'd1:    an[1] = 1'b0;
            2'd2:    an[2] = 1'b0;
            default: an = '1;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// BCD to active-low 7-segment decoder. Non-decimal codes (10-15) show a
// dash so a corrupted digit is visibly distinct from any real value.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg_n
);

    // Pure lookup, no state
    always_comb begin
        o_seg_n = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg_n = SEG_0;
            4'd1:    o_seg_n = SEG_1;
            4'd2:    o_seg_n = SEG_2;
            4'd3:    o_seg_n = SEG_3;
            4'd4:    o_seg_n = SEG_4;
            4'd5:    o_seg_n = SEG_5;
            4'd6:    o_seg_n = SEG_6;
            4'd7:    o_seg_n = SEG_7;
            4'd8:    o_seg_n = SEG_8;
            4'd9:    o_seg_n = SEG_9;
            default: o_seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Three-digit common-anode scan driver. Each digit gets a slot of DIV
// cycles; the first BLANK_CYC cycles of every slot keep all anodes off so
// the previous digit's segments never ghost onto the next anode. Inputs are
// snapshotted once per frame so a frame always shows one coherent value.
// blink gates the anodes live (not snapshotted) for lockout indication.
// Every output is registered from the next-state values, so the pins at a
// given (idx, sc) describe that same (idx, sc).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_HZ    = 125000000,
    parameter int SCAN_HZ   = 1000,
    parameter int BLANK_CYC = 64,  // must be < DIV-1
    parameter int BLINK_HZ  = 2
) (
    input  logic        clk_125Mhz,
    input  logic        rst,
    input  logic [11:0] digits_in,
    input  logic [2:0]  digit_en,
    input  logic [2:0]  dp_in,
    input  logic        blink,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [2:0]  an_n,
    output logic        frame_tick
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int HP  = CLK_HZ / (2 * BLINK_HZ);
    localparam int SCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BCW = (HP > 1) ? $clog2(HP) : 1;

    // Scan state
    logic           r_run;       // 0 only until the first edge after reset
    logic [SCW-1:0] r_sc;
    idx_t           r_idx;

    // Frame snapshot
    logic [11:0]    r_snap_dig;
    logic [2:0]     r_snap_en;
    logic [2:0]     r_snap_dp;

    // Blink timing
    logic [BCW-1:0] r_bcnt;
    logic           r_vis;

    // Registered pin drives
    logic [2:0]     r_an_n;
    logic [6:0]     r_seg_n;
    logic           r_dp_n;
    logic           r_frame_tick;

    // Next-state values
    logic [SCW-1:0] w_sc_nxt;
    idx_t           w_idx_nxt;
    logic           w_snap_load;
    logic [11:0]    w_dig_nxt;
    logic [2:0]     w_en_nxt;
    logic [2:0]     w_dp_nxt;
    logic [BCW-1:0] w_bcnt_nxt;
    logic           w_vis_nxt;

    // Selected-digit view and decoded outputs
    logic [3:0]     w_cur_bcd;
    logic           w_cur_en;
    logic           w_cur_dp;
    logic [6:0]     w_dec_seg_n;
    logic           w_an_on;
    logic [2:0]     w_an_n_nxt;
    logic [6:0]     w_seg_n_nxt;
    logic           w_dp_n_nxt;
    logic           w_tick_nxt;

    // Slot counter and digit index advance; snapshot loads on the 2 -> 0 wrap.
    // The very first edge after reset loads (idx 0, sc 0) so a frame_tick
    // follows reset release by one cycle.
    always_comb begin
        w_sc_nxt    = r_sc;
        w_idx_nxt   = r_idx;
        w_snap_load = 1'b0;
        if (!r_run) begin
            w_sc_nxt  = '0;
            w_idx_nxt = IDX_FIRST;
        end else if (r_sc == SCW'(DIV - 1)) begin
            w_sc_nxt    = '0;
            w_idx_nxt   = idx_next(r_idx);
            w_snap_load = (r_idx == IDX_LAST);
        end else begin
            w_sc_nxt = r_sc + SCW'(1);
        end
    end

    // Snapshot next values: inputs only become visible at a frame boundary
    always_comb begin
        w_dig_nxt = r_snap_dig;
        w_en_nxt  = r_snap_en;
        w_dp_nxt  = r_snap_dp;
        if (w_snap_load) begin
            w_dig_nxt = digits_in;
            w_en_nxt  = digit_en;
            w_dp_nxt  = dp_in;
        end
    end

    // Blink half-period counter; idle at 0 / visible so blink starts lit
    always_comb begin
        w_bcnt_nxt = r_bcnt;
        w_vis_nxt  = r_vis;
        if (!blink) begin
            w_bcnt_nxt = '0;
            w_vis_nxt  = 1'b1;
        end else if (r_bcnt == BCW'(HP - 1)) begin
            w_bcnt_nxt = '0;
            w_vis_nxt  = ~r_vis;
        end else begin
            w_bcnt_nxt = r_bcnt + BCW'(1);
        end
    end

    // Pick the digit, enable and dp belonging to the upcoming slot
    always_comb begin
        w_cur_bcd = w_dig_nxt[3:0];
        w_cur_en  = w_en_nxt[0];
        w_cur_dp  = w_dp_nxt[0];
        case (w_idx_nxt)
            2'd1: begin
                w_cur_bcd = w_dig_nxt[7:4];
                w_cur_en  = w_en_nxt[1];
                w_cur_dp  = w_dp_nxt[1];
            end
            2'd2: begin
                w_cur_bcd = w_dig_nxt[11:8];
                w_cur_en  = w_en_nxt[2];
                w_cur_dp  = w_dp_nxt[2];
            end
            default: begin
                w_cur_bcd = w_dig_nxt[3:0];
                w_cur_en  = w_en_nxt[0];
                w_cur_dp  = w_dp_nxt[0];
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .i_bcd   (w_cur_bcd),
        .o_seg_n (w_dec_seg_n)
    );

    // Anode gating: past the blank window, digit enabled, and not in the
    // dark half of a blink. Segments and dp follow the anode so a dark slot
    // drives nothing at all.
    always_comb begin
        w_an_on     = (w_sc_nxt >= SCW'(BLANK_CYC)) && w_cur_en &&
                      (!blink || r_vis) && (w_idx_nxt <= IDX_LAST);
        w_an_n_nxt  = 3'b111;
        w_seg_n_nxt = SEG_OFF;
        w_dp_n_nxt  = 1'b1;
        if (w_an_on) begin
            w_an_n_nxt  = anode_sel(w_idx_nxt);
            w_seg_n_nxt = w_dec_seg_n;
            w_dp_n_nxt  = ~w_cur_dp;
        end
        w_tick_nxt = (w_sc_nxt == '0) && (w_idx_nxt == IDX_FIRST);
    end

    // Scan and snapshot registers
    always_ff @(posedge clk_125Mhz or posedge rst) begin
        if (rst) begin
            r_run      <= 1'b0;
            r_sc       <= '0;
            r_idx      <= IDX_FIRST;
            r_snap_dig <= '0;
            r_snap_en  <= '0;
            r_snap_dp  <= '0;
        end else begin
            r_run      <= 1'b1;
            r_sc       <= w_sc_nxt;
            r_idx      <= w_idx_nxt;
            r_snap_dig <= w_dig_nxt;
            r_snap_en  <= w_en_nxt;
            r_snap_dp  <= w_dp_nxt;
        end
    end

    // Blink registers
    always_ff @(posedge clk_125Mhz or posedge rst) begin
        if (rst) begin
            r_bcnt <= '0;
            r_vis  <= 1'b1;
        end else begin
            r_bcnt <= w_bcnt_nxt;
            r_vis  <= w_vis_nxt;
        end
    end

    // Output registers, all dark in reset
    always_ff @(posedge clk_125Mhz or posedge rst) begin
        if (rst) begin
            r_an_n       <= 3'b111;
            r_seg_n      <= SEG_OFF;
            r_dp_n       <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_an_n       <= w_an_n_nxt;
            r_seg_n      <= w_seg_n_nxt;
            r_dp_n       <= w_dp_n_nxt;
            r_frame_tick <= w_tick_nxt;
        end
    end

    assign an_n       = r_an_n;
    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIV=10, BLANK_CYC=2, HP=20.
// Positions are counted in cycles from a frame_tick (t=0 at idx 0, sc 0);
// one frame is 30 cycles. Outputs are sampled on the falling edge.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] digits_in = '0;
    logic [2:0]  digit_en = '0;
    logic [2:0]  dp_in = '0;
    logic        blink = 1'b0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [2:0]  an_n;
    logic        frame_tick;

    seg7_scan_driver #(
        .CLK_HZ    (1000),
        .SCAN_HZ   (100),
        .BLANK_CYC (2),
        .BLINK_HZ  (25)
    ) dut (
        .clk_125Mhz (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .blink      (blink),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         set;
        int         t;
        logic [2:0] an;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    vec_t tbl[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   t = 0;

    function automatic vec_t mk(int s, int tt, logic [2:0] a, logic [6:0] sg, logic d);
        vec_t v;
        v.set = s; v.t = tt; v.an = a; v.seg = sg; v.dp = d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, got, exp, t);
    endtask

    // Advance one cycle, landing on the next falling edge
    task automatic step1();
        @(posedge clk);
        @(negedge clk);
        t++;
    endtask

    task automatic step_to(input int target);
        while (t < target) step1();
    endtask

    // Move to the next frame_tick (always at least one cycle forward)
    task automatic sync_frame();
        int k;
        k = 0;
        step1();
        while (frame_tick !== 1'b1 && k < 100) begin
            step1();
            k++;
        end
        chk("sync_frame_tick", {31'd0, frame_tick}, 32'd1);
        t = 0;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] a, input logic [6:0] sg, input logic d);
        chk($sformatf("%s an_n", tag), {29'd0, an_n}, {29'd0, a});
        chk($sformatf("%s seg_n", tag), {25'd0, seg_n}, {25'd0, sg});
        chk($sformatf("%s dp_n", tag), {31'd0, dp_n}, {31'd0, d});
    endtask

    task automatic run_set(input int s);
        sync_frame();
        foreach (tbl[i]) begin
            if (tbl[i].set == s) begin
                step_to(tbl[i].t);
                chk_out($sformatf("set%0d t%0d", s, tbl[i].t), tbl[i].an, tbl[i].seg, tbl[i].dp);
            end
        end
    endtask

    initial begin
        int k;

        // set 0: 122, all enabled, no dp
        tbl.push_back(mk(0,  0, 3'b111, 7'h7F, 1'b1));
        tbl.push_back(mk(0,  1, 3'b111, 7'h7F, 1'b1));
        tbl.push_back(mk(0,  2, 3'b110, 7'b0100100, 1'b1));
        tbl.push_back(mk(0,  9, 3'b110, 7'b0100100, 1'b1));
        tbl.push_back(mk(0, 10, 3'b111, 7'h7F, 1'b1));
        tbl.push_back(mk(0, 11, 3'b111, 7'h7F, 1'b1));
        tbl.push_back(mk(0, 12, 3'b101, 7'b0100100, 1'b1));
        tbl.push_back(mk(0, 19, 3'b101, 7'b0100100, 1'b1));
        tbl.push_back(mk(0, 20, 3'b111, 7'h7F, 1'b1));
        tbl.push_back(mk(0, 22, 3'b011, 7'b1111001, 1'b1));
        tbl.push_back(mk(0, 29, 3'b011, 7'b1111001, 1'b1));
        // set 1: F05, en=101, dp=010 -> '5', dark, dash
        tbl.push_back(mk(1,  2, 3'b110, 7'b0010010, 1'b1));
        tbl.push_back(mk(1,  9, 3'b110, 7'b0010010, 1'b1));
        tbl.push_back(mk(1, 12, 3'b111, 7'h7F, 1'b1));
        tbl.push_back(mk(1, 15, 3'b111, 7'h7F, 1'b1));
        tbl.push_back(mk(1, 22, 3'b011, 7'b0111111, 1'b1));
        tbl.push_back(mk(1, 27, 3'b011, 7'b0111111, 1'b1));
        // set 2: 123, all enabled, dp=101
        tbl.push_back(mk(2,  2, 3'b110, 7'b0110000, 1'b0));
        tbl.push_back(mk(2, 12, 3'b101, 7'b0100100, 1'b1));
        tbl.push_back(mk(2, 20, 3'b111, 7'h7F, 1'b1));
        tbl.push_back(mk(2, 22, 3'b011, 7'b1111001, 1'b0));

        // Reset held for 5 cycles
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_out("reset", 3'b111, 7'h7F, 1'b1);
        chk("reset frame_tick", {31'd0, frame_tick}, 32'd0);

        // Release: first edge loads idx 0 / sc 0 and pulses frame_tick
        digits_in = 12'h122; digit_en = 3'b111; dp_in = 3'b000;
        rst = 1'b0;
        step1();
        t = 0;
        chk("first frame_tick", {31'd0, frame_tick}, 32'd1);
        step1();
        chk("frame_tick width", {31'd0, frame_tick}, 32'd0);
        // Snapshot still cleared for the first frame: everything dark
        step_to(5);
        chk_out("first frame dark", 3'b111, 7'h7F, 1'b1);
        // Frame period
        k = 5;
        while (frame_tick !== 1'b1 && k < 60) begin
            step1();
            k++;
        end
        chk("frame period", k, 32'd30);

        // Scan order
        run_set(0);

        // Snapshot coherence: change mid-frame during idx 1
        sync_frame();
        step_to(10);
        digits_in = 12'h999;
        step_to(12);
        chk_out("snap old d1", 3'b101, 7'b0100100, 1'b1);
        step_to(22);
        chk_out("snap old d2", 3'b011, 7'b1111001, 1'b1);
        sync_frame();
        step_to(2);
        chk_out("snap new d0", 3'b110, 7'b0010000, 1'b1);

        // Enable / dash / dp
        digits_in = 12'hF05; digit_en = 3'b101; dp_in = 3'b010;
        run_set(1);
        digits_in = 12'h123; digit_en = 3'b111; dp_in = 3'b101;
        run_set(2);

        // Blink: visible t=1..20, dark 21..40, visible 41..60, dark 61..
        digits_in = 12'h888; dp_in = 3'b000;
        sync_frame();
        sync_frame();
        blink = 1'b1;
        step_to(5);  chk("blink vis t5",   {29'd0, an_n}, 32'b110);
        step_to(15); chk("blink vis t15",  {29'd0, an_n}, 32'b101);
        step_to(19); chk("blink vis t19",  {29'd0, an_n}, 32'b101);
        step_to(25); chk_out("blink dark t25", 3'b111, 7'h7F, 1'b1);
        step_to(35); chk("blink dark t35", {29'd0, an_n}, 32'b111);
        step_to(39); chk("blink dark t39", {29'd0, an_n}, 32'b111);
        step_to(45); chk("blink vis t45",  {29'd0, an_n}, 32'b101);
        step_to(55); chk("blink vis t55",  {29'd0, an_n}, 32'b011);
        step_to(65); chk("blink dark t65", {29'd0, an_n}, 32'b111);
        blink = 1'b0;
        step_to(66); chk_out("unblink t66", 3'b110, 7'b0000000, 1'b1);

        // Async reset at idx 2, sc 5
        sync_frame();
        step_to(25);
        chk_out("pre-reset d2", 3'b011, 7'b0000000, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_out("async reset", 3'b111, 7'h7F, 1'b1);
        chk("async reset tick", {31'd0, frame_tick}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step1();
        t = 0;
        chk("post-reset tick", {31'd0, frame_tick}, 32'd1);
        step_to(2);
        chk("cleared snap d0", {29'd0, an_n}, 32'b111);
        step_to(22);
        chk("cleared snap d2", {29'd0, an_n}, 32'b111);
        sync_frame();
        step_to(2);
        chk_out("reload d0", 3'b110, 7'b0000000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
